packet_queue: RTL and testbench

//  Flow-controlled packet buffer feeding a router output. It stores whole multi-flit packets in a ring buffer.
//  Per-packet descriptors go in a small FIFO. The head packet is offered to the routing logic, which then streams it out or drops it.

---
 rtl/packet_buffer_pkg.sv | 25 ++
 rtl/pkt_desc_fifo.sv | 44 ++++
 rtl/packet_queue.sv | 216 +++++++++++++++++++++
 tb/tb_packet_queue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_buffer_pkg.sv
// Shared types for the packet queue: FSM state encodings and the per-packet descriptor.
// Descriptor fields are sized for the widest supported flit and ring pointer.
package packet_buffer_pkg;

   localparam int DESC_HDR_W  = 64;
   localparam int DESC_BASE_W = 16;

   typedef enum logic {
      WR_HEADER,
      WR_BODY
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_READY,
      RD_STREAM,
      RD_DUMP
   } rd_state_t;

   typedef struct packed {
      logic [DESC_HDR_W-1:0]  header;
      logic [DESC_BASE_W-1:0] base;
   } desc_t;

endpackage

// File: rtl/pkt_desc_fifo.sv
// Synchronous descriptor FIFO with asynchronous active-low reset.
// Exposes the head entry and the entry behind it so a pop can preload the next header.
module pkt_desc_fifo
   import packet_buffer_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  desc_t                  push_data,
   input  logic                   pop,
   output desc_t                  head,
   output desc_t                  second,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   desc_t         entries [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= CW'(32'(count) + 32'(push) - 32'(pop));
      end
   end

   always_ff @(posedge clk) begin
      if (push) entries[wr_ptr] <= push_data;
   end

   assign head   = entries[rd_ptr];
   assign second = entries[rd_ptr + 1'b1];

endmodule

// File: rtl/packet_queue.sv
// Flow-controlled packet buffer: whole packets in a ring buffer, descriptors in a FIFO,
// head packet offered to routing logic for stream-out or single-cycle drop.
module packet_queue
   import packet_buffer_pkg::*;
#(
   parameter int BUFFER_DEPTH          = 256,
   parameter int FLIT_SIZE             = 64,
   parameter int MAX_PACKETS           = 16,
   parameter int TO_ADDRESS_MSB        = 63,
   parameter int TO_ADDRESS_LSB        = 56,
   parameter int FROM_ADDRESS_MSB      = 55,
   parameter int FROM_ADDRESS_LSB      = 48,
   parameter int PACKET_LENGTH_MSB     = 47,
   parameter int PACKET_LENGTH_LSB     = 40
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [FLIT_SIZE-1:0]                           in_flit,
   input  logic                                           in_flit_valid,
   output logic                                           in_flit_ready,
   input  logic                                           control_valid,
   input  logic                                           stream,
   input  logic                                           drop,
   output logic                                           control_ready,
   output logic                                           control_error,
   output logic                                           packet_ready,
   output logic [TO_ADDRESS_MSB-TO_ADDRESS_LSB:0]         to_addr,
   output logic [FROM_ADDRESS_MSB-FROM_ADDRESS_LSB:0]     from_addr,
   output logic [PACKET_LENGTH_MSB-PACKET_LENGTH_LSB:0]   packet_length,
   output logic [$clog2(MAX_PACKETS):0]                   n_packets,
   output logic [$clog2(BUFFER_DEPTH):0]                  n_flits,
   output logic [FLIT_SIZE-1:0]                           out_flit,
   output logic                                           out_flit_valid,
   output logic                                           out_flit_last,
   input  logic                                           out_flit_ready
);

   localparam int PTR_W = $clog2(BUFFER_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LEN_W = PACKET_LENGTH_MSB - PACKET_LENGTH_LSB + 1;

   logic [FLIT_SIZE-1:0] mem [BUFFER_DEPTH];

   wr_state_t         wr_state, wr_next;
   logic [PTR_W-1:0]  wr_ptr;
   logic [LEN_W-1:0]  body_left;
   logic [LEN_W-1:0]  in_len;
   desc_t             open_desc, new_desc, push_data, head, second;
   logic              hdr_fits, accept, push, pop;
   logic [31:0]       freed;

   rd_state_t         rd_state, rd_next;
   desc_t             cur;
   logic [LEN_W-1:0]  rd_idx, rd_len;
   logic [PTR_W-1:0]  rd_base, rd_addr;
   logic              cmd_stream, cmd_drop, cmd_bad, is_last, more;
   logic              rd_start, rd_adv;
   logic              unused_desc;

   pkt_desc_fifo #(.DEPTH(MAX_PACKETS)) u_desc_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .second    (second),
      .count     (n_packets)
   );

   // ---------------- write side ----------------
   assign in_len   = in_flit[PACKET_LENGTH_MSB:PACKET_LENGTH_LSB];
   assign new_desc = '{header: DESC_HDR_W'(in_flit), base: DESC_BASE_W'(wr_ptr)};
   // Slots freed by the read side this cycle count as free, so a header can enter on the freeing edge.
   assign hdr_fits = (32'(in_len) + 32'd1 <= 32'(BUFFER_DEPTH) - 32'(n_flits) + freed)
                     && (32'(n_packets) < 32'(MAX_PACKETS));
   assign accept   = in_flit_valid && in_flit_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wr_state <= WR_HEADER;
      else      wr_state <= wr_next;
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_HEADER: if (accept && in_len != '0) wr_next = WR_BODY;
         WR_BODY:   if (accept && body_left == LEN_W'(1)) wr_next = WR_HEADER;
         default:   wr_next = WR_HEADER;
      endcase
   end

   always_comb begin
      in_flit_ready = 1'b0;
      push          = 1'b0;
      push_data     = open_desc;
      case (wr_state)
         WR_HEADER: begin
            in_flit_ready = rst && hdr_fits;
            push          = rst && hdr_fits && in_flit_valid && in_len == '0;
            push_data     = new_desc;
         end
         WR_BODY: begin
            in_flit_ready = rst;
            push          = rst && in_flit_valid && body_left == LEN_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         body_left <= '0;
         open_desc <= '0;
         n_flits   <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_state == WR_HEADER) begin
               open_desc <= new_desc;
               body_left <= in_len;
            end else begin
               body_left <= body_left - 1'b1;
            end
         end
         n_flits <= CNT_W'(32'(n_flits) + 32'(accept) - freed);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= in_flit;
   end

   // ---------------- read side ----------------
   assign rd_len     = cur.header[PACKET_LENGTH_MSB:PACKET_LENGTH_LSB];
   assign rd_base    = PTR_W'(cur.base);
   assign cmd_stream = control_valid && stream && !drop;
   assign cmd_drop   = control_valid && drop && !stream;
   assign cmd_bad    = control_valid && (stream == drop);
   assign is_last    = rd_idx == rd_len;
   assign more       = 32'(n_packets) > 32'd1;
   assign freed      = pop ? 32'(rd_len) + 32'd1 : 32'd0;
   assign rd_addr    = rd_start ? rd_base : rd_base + PTR_W'(rd_idx) + 1'b1;

   assign to_addr       = cur.header[TO_ADDRESS_MSB:TO_ADDRESS_LSB];
   assign from_addr     = cur.header[FROM_ADDRESS_MSB:FROM_ADDRESS_LSB];
   assign packet_length = rd_len;
   assign unused_desc   = ^{cur.header, cur.base};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_state <= RD_IDLE;
      else      rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE:   if (n_packets != '0) rd_next = RD_READY;
         RD_READY: begin
            if (cmd_stream)    rd_next = RD_STREAM;
            else if (cmd_drop) rd_next = RD_DUMP;
         end
         RD_STREAM: if (out_flit_ready && is_last) rd_next = more ? RD_READY : RD_IDLE;
         RD_DUMP:   rd_next = more ? RD_READY : RD_IDLE;
         default:   rd_next = RD_IDLE;
      endcase
   end

   always_comb begin
      packet_ready   = 1'b0;
      control_ready  = 1'b0;
      out_flit_valid = 1'b0;
      out_flit_last  = 1'b0;
      pop            = 1'b0;
      rd_start       = 1'b0;
      rd_adv         = 1'b0;
      case (rd_state)
         RD_READY: begin
            packet_ready  = 1'b1;
            control_ready = 1'b1;
            rd_start      = cmd_stream;
         end
         RD_STREAM: begin
            out_flit_valid = 1'b1;
            out_flit_last  = is_last;
            pop            = out_flit_ready && is_last;
            rd_adv         = out_flit_ready && !is_last;
         end
         RD_DUMP: pop = 1'b1;
         default: ;
      endcase
   end

   // On a pop the next head is the FIFO's second entry, so header outputs are valid on entering READY.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur           <= '0;
         rd_idx        <= '0;
         out_flit      <= '0;
         control_error <= 1'b0;
      end else begin
         control_error <= (rd_state == RD_READY) && cmd_bad;
         if (rd_state == RD_IDLE && n_packets != '0) cur <= head;
         else if (pop && more)                        cur <= second;
         if (rd_start) begin
            rd_idx   <= '0;
            out_flit <= mem[rd_addr];
         end else if (rd_adv) begin
            rd_idx   <= rd_idx + 1'b1;
            out_flit <= mem[rd_addr];
         end
      end
   end

endmodule

// File: tb/tb_packet_queue.sv
// Directed plus randomized bench for packet_queue (8-slot ring, 4 descriptors),
// checked against a queue-of-flits reference model.
module tb_packet_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_flit;
   logic        in_flit_valid, in_flit_ready;
   logic        control_valid, stream, drop, control_ready, control_error;
   logic        packet_ready;
   logic [7:0]  to_addr, from_addr, packet_length;
   logic [2:0]  n_packets;
   logic [3:0]  n_flits;
   logic [63:0] out_flit;
   logic        out_flit_valid, out_flit_last, out_flit_ready;

   packet_queue #(.BUFFER_DEPTH(8), .FLIT_SIZE(64), .MAX_PACKETS(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_flit        (in_flit),
      .in_flit_valid  (in_flit_valid),
      .in_flit_ready  (in_flit_ready),
      .control_valid  (control_valid),
      .stream         (stream),
      .drop           (drop),
      .control_ready  (control_ready),
      .control_error  (control_error),
      .packet_ready   (packet_ready),
      .to_addr        (to_addr),
      .from_addr      (from_addr),
      .packet_length  (packet_length),
      .n_packets      (n_packets),
      .n_flits        (n_flits),
      .out_flit       (out_flit),
      .out_flit_valid (out_flit_valid),
      .out_flit_last  (out_flit_last),
      .out_flit_ready (out_flit_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: every stored flit in arrival order, plus body length of each complete packet.
   logic [63:0] m_data[$];
   int          m_len[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] make_header(input logic [7:0] to, input logic [7:0] from, input int len);
      logic [63:0] h;
      h = {$urandom, $urandom};
      h[63:56] = to;
      h[55:48] = from;
      h[47:40] = 8'(len);
      return h;
   endfunction

   task automatic put_flit(input logic [63:0] f);
      int n;
      n = 0;
      in_flit = f;
      in_flit_valid = 1'b1;
      @(negedge clk);
      while (!in_flit_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 64'(in_flit_ready), 64'd1);
      @(posedge clk); #1;
      in_flit_valid = 1'b0;
   endtask

   task automatic send_packet(input logic [7:0] to, input logic [7:0] from, input int len);
      logic [63:0] f;
      f = make_header(to, from, len);
      put_flit(f);
      m_data.push_back(f);
      for (int i = 0; i < len; i++) begin
         f = {$urandom, $urandom};
         put_flit(f);
         m_data.push_back(f);
      end
      m_len.push_back(len);
      @(negedge clk);
      check("send_n_packets", 64'(n_packets), 64'(m_len.size()));
      check("send_n_flits", 64'(n_flits), 64'(m_data.size()));
      @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      logic [63:0] hd;
      int n;
      n = 0;
      @(negedge clk);
      while (!packet_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      hd = m_data[0];
      check("packet_ready", 64'(packet_ready), 64'd1);
      check("hdr_to", 64'(to_addr), 64'(hd[63:56]));
      check("hdr_from", 64'(from_addr), 64'(hd[55:48]));
      check("hdr_len", 64'(packet_length), 64'(hd[47:40]));
      @(posedge clk); #1;
   endtask

   task automatic stream_packet(input bit toggle);
      int len, i, stalls;
      wait_ready();
      len = m_len[0];
      control_valid = 1'b1; stream = 1'b1; drop = 1'b0;
      @(negedge clk);
      check("ctrl_ready_stream", 64'(control_ready), 64'd1);
      @(posedge clk); #1;
      control_valid = 1'b0; stream = 1'b0;
      i = 0;
      stalls = 0;
      while (i <= len) begin
         out_flit_ready = toggle ? ($urandom_range(0, 1) == 1 || stalls >= 3) : 1'b1;
         @(negedge clk);
         check("out_valid", 64'(out_flit_valid), 64'd1);
         check("out_flit", out_flit, m_data[i]);
         check("out_last", 64'(out_flit_last), 64'(i == len));
         @(posedge clk); #1;
         if (out_flit_ready) begin
            i++;
            stalls = 0;
         end else begin
            stalls++;
         end
      end
      out_flit_ready = 1'b0;
      for (int k = 0; k <= len; k++) void'(m_data.pop_front());
      void'(m_len.pop_front());
      @(negedge clk);
      check("post_stream_valid", 64'(out_flit_valid), 64'd0);
      check("post_stream_n_flits", 64'(n_flits), 64'(m_data.size()));
      check("post_stream_n_packets", 64'(n_packets), 64'(m_len.size()));
      @(posedge clk); #1;
   endtask

   task automatic drop_head();
      logic [63:0] hd;
      int len;
      wait_ready();
      len = m_len[0];
      control_valid = 1'b1; drop = 1'b1; stream = 1'b0;
      @(negedge clk);
      check("ctrl_ready_drop", 64'(control_ready), 64'd1);
      @(posedge clk); #1;
      control_valid = 1'b0; drop = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k <= len; k++) void'(m_data.pop_front());
      void'(m_len.pop_front());
      @(negedge clk);
      check("drop_n_flits", 64'(n_flits), 64'(m_data.size()));
      check("drop_n_packets", 64'(n_packets), 64'(m_len.size()));
      check("drop_pkt_ready", 64'(packet_ready), 64'(m_len.size() > 0));
      if (m_len.size() > 0) begin
         hd = m_data[0];
         check("drop_next_to", 64'(to_addr), 64'(hd[63:56]));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] h2, f;
      int free, len;

      rst = 1'b0;
      in_flit = '0; in_flit_valid = 1'b0;
      control_valid = 1'b0; stream = 1'b0; drop = 1'b0;
      out_flit_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_n_flits", 64'(n_flits), 64'd0);
      check("rst_n_packets", 64'(n_packets), 64'd0);
      check("rst_pkt_ready", 64'(packet_ready), 64'd0);
      check("rst_out_valid", 64'(out_flit_valid), 64'd0);
      check("rst_out_flit", out_flit, 64'd0);
      check("rst_ctrl_ready", 64'(control_ready), 64'd0);
      rst = 1'b1;
      #1;
      check("in_ready_after_rst", 64'(in_flit_ready), 64'd1);
      @(posedge clk); #1;

      // commands outside READY are ignored
      control_valid = 1'b1; stream = 1'b1;
      @(negedge clk);
      check("idle_ctrl_ready", 64'(control_ready), 64'd0);
      @(posedge clk); #1;
      control_valid = 1'b0; stream = 1'b0;
      @(negedge clk);
      check("idle_no_error", 64'(control_error), 64'd0);
      check("idle_no_stream", 64'(out_flit_valid), 64'd0);
      @(posedge clk); #1;

      // single packet L=2, streamed at full rate
      send_packet(8'hA5, 8'h11, 2);
      stream_packet(1'b0);

      // drop head of two queued packets
      send_packet(8'h21, 8'h31, 0);
      send_packet(8'h42, 8'h52, 3);
      drop_head();
      stream_packet(1'b1);

      // full ring: next header must wait, then enter on the dump cycle
      send_packet(8'h77, 8'h01, 7);
      wait_ready();
      h2 = make_header(8'h99, 8'h02, 2);
      in_flit = h2; in_flit_valid = 1'b1;
      @(negedge clk);
      check("full_hold", 64'(in_flit_ready), 64'd0);
      @(posedge clk); #1;
      control_valid = 1'b1; drop = 1'b1;
      @(negedge clk);
      check("full_hold2", 64'(in_flit_ready), 64'd0);
      check("full_ctrl_ready", 64'(control_ready), 64'd1);
      @(posedge clk); #1;
      control_valid = 1'b0; drop = 1'b0;
      @(negedge clk);
      check("admit_on_free", 64'(in_flit_ready), 64'd1);
      @(posedge clk); #1;
      in_flit_valid = 1'b0;
      for (int k = 0; k < 8; k++) void'(m_data.pop_front());
      void'(m_len.pop_front());
      m_data.push_back(h2);
      for (int k = 0; k < 2; k++) begin
         f = {$urandom, $urandom};
         put_flit(f);
         m_data.push_back(f);
      end
      m_len.push_back(2);
      @(negedge clk);
      check("refill_n_flits", 64'(n_flits), 64'd3);
      check("refill_n_packets", 64'(n_packets), 64'd1);
      @(posedge clk); #1;
      stream_packet(1'b1);

      // wrap: second packet spans slots 5,6,7,0,1
      send_packet(8'h13, 8'h14, 1);
      send_packet(8'h15, 8'h16, 4);
      stream_packet(1'b1);
      stream_packet(1'b1);

      // malformed commands: stream==drop
      send_packet(8'hE0, 8'hE1, 1);
      wait_ready();
      for (int p = 0; p < 2; p++) begin
         control_valid = 1'b1; stream = p[0] ? 1'b0 : 1'b1; drop = stream;
         @(negedge clk);
         check("err_ctrl_ready", 64'(control_ready), 64'd1);
         @(posedge clk); #1;
         control_valid = 1'b0; stream = 1'b0; drop = 1'b0;
         @(negedge clk);
         check("err_pulse", 64'(control_error), 64'd1);
         check("err_stay_ready", 64'(packet_ready), 64'd1);
         @(posedge clk); #1;
         @(negedge clk);
         check("err_pulse_end", 64'(control_error), 64'd0);
         check("err_no_stream", 64'(out_flit_valid), 64'd0);
         @(posedge clk); #1;
      end
      stream_packet(1'b0);

      // randomized traffic
      for (int it = 0; it < 60; it++) begin
         free = 8 - m_data.size();
         if (m_len.size() < 4 && free >= 1 && (m_len.size() == 0 || $urandom_range(0, 1) == 1)) begin
            len = $urandom_range(0, (free - 1 < 7) ? free - 1 : 7);
            send_packet(8'($urandom), 8'($urandom), len);
         end else if ($urandom_range(0, 3) == 0) begin
            drop_head();
         end else begin
            stream_packet(1'b1);
         end
      end
      while (m_len.size() > 0) stream_packet(1'b0);

      // reset mid-stream
      send_packet(8'hC3, 8'hC4, 5);
      wait_ready();
      control_valid = 1'b1; stream = 1'b1;
      @(posedge clk); #1;
      control_valid = 1'b0; stream = 1'b0;
      out_flit_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_flit_valid), 64'd0);
      check("midrst_n_flits", 64'(n_flits), 64'd0);
      check("midrst_n_packets", 64'(n_packets), 64'd0);
      check("midrst_pkt_ready", 64'(packet_ready), 64'd0);
      out_flit_ready = 1'b0;
      m_data.delete();
      m_len.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      in_flit = '0;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_flit_ready), 64'd1);
      check("post_rst_n_flits", 64'(n_flits), 64'd0);
      @(posedge clk); #1;
      send_packet(8'h5A, 8'h6B, 1);
      stream_packet(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
